// File: rtl/reg_file_wb_pkg.sv
// Shared widths and fixed register indices for the write-back register file.
package reg_file_wb_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int LINK_REG = 31;
  localparam int REG_ZERO = 0;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/reg_file_wb_bypass_port.sv
// One read port: selects the stored word, the same-edge write, or hardwired zero.
module rf_bypass_port
  import reg_file_wb_pkg::*;
(
  input  logic [DATA_W-1:0] arr_word,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              eff_valid,
  input  logic [ADDR_W-1:0] eff_addr,
  input  logic [DATA_W-1:0] eff_data,
  output logic [DATA_W-1:0] rd_next
);

  // A match on a non-zero index implies the write is not to r0.
  always_comb begin
    rd_next = arr_word;
    if (rd_addr == ADDR_W'(REG_ZERO)) begin
      rd_next = '0;
    end else if (eff_valid && (eff_addr == rd_addr)) begin
      rd_next = eff_data;
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// 32x32 MIPS register file with link write, r0 hardwired zero and write->read bypass.
module reg_file_wb
  import reg_file_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_en,
  input  logic [DATA_W-1:0] link_pc,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              wr_conflict
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] ra_data_q, ra_data_d;
  logic [DATA_W-1:0] rb_data_q, rb_data_d;
  logic              wr_conflict_q, wr_conflict_d;

  logic              eff_valid;
  logic [ADDR_W-1:0] eff_addr;
  logic [DATA_W-1:0] eff_data;
  logic [DATA_W-1:0] ra_next, rb_next;

  // Link writes win; a concurrent normal write is dropped and flagged.
  always_comb begin
    eff_valid     = link_en | wr_en;
    eff_addr      = link_en ? ADDR_W'(LINK_REG) : wr_addr;
    eff_data      = link_en ? link_pc : wr_data;
    wr_conflict_d = link_en & wr_en;
  end

  rf_bypass_port u_port_a (
    .arr_word  (regs_q[ra_addr]),
    .rd_addr   (ra_addr),
    .eff_valid (eff_valid),
    .eff_addr  (eff_addr),
    .eff_data  (eff_data),
    .rd_next   (ra_next)
  );

  rf_bypass_port u_port_b (
    .arr_word  (regs_q[rb_addr]),
    .rd_addr   (rb_addr),
    .eff_valid (eff_valid),
    .eff_addr  (eff_addr),
    .eff_data  (eff_data),
    .rd_next   (rb_next)
  );

  always_comb begin
    regs_d = regs_q;
    if (eff_valid && (eff_addr != ADDR_W'(REG_ZERO))) begin
      regs_d[eff_addr] = eff_data;
    end
    ra_data_d = rd_en ? ra_next : ra_data_q;
    rb_data_d = rd_en ? rb_next : rb_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      ra_data_q     <= '0;
      rb_data_q     <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      ra_data_q     <= ra_data_d;
      rb_data_q     <= rb_data_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign ra_data     = ra_data_q;
  assign rb_data     = rb_data_q;
  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: directed cases plus random traffic against an array model.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, link_en, rd_en;
  logic [4:0]  wr_addr, ra_addr, rb_addr;
  logic [31:0] wr_data, link_pc;
  logic [31:0] ra_data, rb_data;
  logic        wr_conflict;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] ra;
    logic [31:0] rb;
    logic        conflict;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[32];
  logic [31:0] exp_ra, exp_rb;

  reg_file_wb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .link_en     (link_en),
    .link_pc     (link_pc),
    .rd_en       (rd_en),
    .ra_addr     (ra_addr),
    .rb_addr     (rb_addr),
    .ra_data     (ra_data),
    .rb_data     (rb_data),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = '0;
    exp_ra = '0;
    exp_rb = '0;
  endtask

  // Register-file semantics in plain terms: what each register holds after this
  // edge, and what a read returns when it sees the write of the same edge.
  task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic le, input logic [31:0] lpc,
                       input logic re, input logic [4:0] ra, input logic [4:0] rb);
    exp_t        e;
    logic [31:0] next[32];
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd;
    link_en = le; link_pc = lpc;
    rd_en = re; ra_addr = ra; rb_addr = rb;
    next = model;
    if (le) next[31] = lpc;
    else if (we && wa != 0) next[wa] = wd;
    if (re) begin
      exp_ra = next[ra];
      exp_rb = next[rb];
    end
    e.ra = exp_ra;
    e.rb = exp_rb;
    e.conflict = le && we;
    sb.push_back(e);
    model = next;
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 5'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0 && rst_n) begin
        e = sb.pop_front();
        chk("ra_data", ra_data, e.ra);
        chk("rb_data", rb_data, e.rb);
        chk("wr_conflict", {31'd0, wr_conflict}, {31'd0, e.conflict});
      end
    end
  end

  initial begin : stim
    wr_en = 0; wr_addr = 0; wr_data = 0; link_en = 0; link_pc = 0;
    rd_en = 0; ra_addr = 0; rb_addr = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset ra_data", ra_data, 32'd0);
    chk("reset rb_data", rb_data, 32'd0);
    chk("reset wr_conflict", {31'd0, wr_conflict}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // mid-cycle reset clears the outputs immediately and the array contents
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'd0, 1'b1, 5'd5, 5'd5);
    idle();
    drain();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async reset ra_data", ra_data, 32'd0);
    chk("async reset rb_data", rb_data, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd5, 5'd0);

    // plain write then read
    cycle(1'b1, 5'd7, 32'h12345678, 1'b0, 32'd0, 1'b0, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd7, 5'd0);
    // both ports bypass the same-edge write
    cycle(1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 32'd0, 1'b1, 5'd9, 5'd9);
    // link priority and conflict pulse
    cycle(1'b1, 5'd3, 32'h0000_00AA, 1'b0, 32'd0, 1'b0, 5'd0, 5'd0);
    cycle(1'b1, 5'd3, 32'h0000_0001, 1'b1, 32'h00400010, 1'b1, 5'd31, 5'd3);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd31, 5'd3);
    // r0 stays zero, same edge and later
    cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b1, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd0, 5'd7);
    // read hold during stall while the write still commits
    cycle(1'b1, 5'd4, 32'h0000_0011, 1'b0, 32'd0, 1'b1, 5'd4, 5'd4);
    cycle(1'b1, 5'd4, 32'h0000_0055, 1'b0, 32'd0, 1'b0, 5'd4, 5'd4);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd4, 5'd9);
    drain();

    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa, ra, rb;
      wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      cycle(1'($urandom_range(0, 1)), wa, $urandom,
            ($urandom_range(0, 7) == 0), $urandom,
            ($urandom_range(0, 3) != 0), ra, rb);
    end
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
